// File: rtl/universal_bin_counter_pkg.sv
// Shared definitions for the universal binary counter: default width and direction encoding.
package counter_pkg;

    localparam int unsigned COUNTER_W = 8;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage : counter_pkg

// File: rtl/universal_bin_counter.sv
// Universal N-bit up/down binary counter with synchronous clear, parallel load,
// count enable and terminal-count decodes.
//
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-high reset, forces q to 0
//   syn_clr  - synchronous clear (highest priority)
//   load     - synchronous parallel load of d
//   en       - count enable
//   up       - direction when counting: 1 = increment, 0 = decrement
//   d        - parallel-load data
//   max_tick - high while q is all ones
//   min_tick - high while q is zero
//   q        - current count, straight from the state register
module universal_bin_counter
    import counter_pkg::*;
#(
    parameter int unsigned N = COUNTER_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         syn_clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [N-1:0] d,
    output logic         max_tick,
    output logic         min_tick,
    output logic [N-1:0] q
);

    logic [N-1:0] q_next;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

    // Priority chain: clear > load > count > hold. Carry/borrow drops off the top bit.
    always_comb begin
        q_next = q;
        if (syn_clr) begin
            q_next = '0;
        end else if (load) begin
            q_next = d;
        end else if (en) begin
            if (dir_e'(up) == DIR_UP) begin
                q_next = q + N'(1);
            end else begin
                q_next = q - N'(1);
            end
        end
    end

    // Terminal-count decodes depend on q alone.
    assign max_tick = (q == {N{1'b1}});
    assign min_tick = (q == '0);

endmodule : universal_bin_counter

// File: tb/tb_universal_bin_counter.sv
// Directed self-checking bench for universal_bin_counter (default 8-bit width).
module tb_universal_bin_counter;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset;
    logic         syn_clr;
    logic         load;
    logic         en;
    logic         up;
    logic [W-1:0] d;
    logic         max_tick;
    logic         min_tick;
    logic [W-1:0] q;

    int tests;
    int fails;

    universal_bin_counter #(.N(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .syn_clr  (syn_clr),
        .load     (load),
        .en       (en),
        .up       (up),
        .d        (d),
        .max_tick (max_tick),
        .min_tick (min_tick),
        .q        (q)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Compare q and both flags against expected values.
    task automatic chk(input string tag, input logic [W-1:0] exp_q,
                       input logic exp_max, input logic exp_min);
        tests++;
        assert (q === exp_q)
        else begin
            fails++;
            $error("FAIL %s q: got %h expected %h", tag, q, exp_q);
        end
        tests++;
        assert (max_tick === exp_max)
        else begin
            fails++;
            $error("FAIL %s max_tick: got %b expected %b", tag, max_tick, exp_max);
        end
        tests++;
        assert (min_tick === exp_min)
        else begin
            fails++;
            $error("FAIL %s min_tick: got %b expected %b", tag, min_tick, exp_min);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] up_seq [4];
        logic [W-1:0] dn_seq [4];
        up_seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        dn_seq = '{8'h01, 8'h00, 8'hFF, 8'hFE};
        tests   = 0;
        fails   = 0;

        // Reset during first half cycle, no clock edge yet.
        reset   = 1'b1;
        syn_clr = 1'b0;
        load    = 1'b0;
        en      = 1'b0;
        up      = 1'b0;
        d       = '0;
        #2;
        chk("reset", 8'h00, 1'b0, 1'b1);
        #3;
        reset = 1'b0;

        // Hold with en=0.
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold", 8'h00, 1'b0, 1'b1);
        end

        // Up-count wrap from FD.
        load = 1'b1;
        d    = 8'hFD;
        step();
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        chk("up_load", 8'hFD, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("up_wrap", up_seq[i], up_seq[i] == 8'hFF, up_seq[i] == 8'h00);
        end

        // Down-count wrap from 02.
        en   = 1'b0;
        load = 1'b1;
        d    = 8'h02;
        step();
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b0;
        chk("dn_load", 8'h02, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dn_wrap", dn_seq[i], dn_seq[i] == 8'hFF, dn_seq[i] == 8'h00);
        end

        // Priority: clear beats load and count.
        en   = 1'b0;
        load = 1'b1;
        d    = 8'h40;
        step();
        chk("prio_pre", 8'h40, 1'b0, 1'b0);
        syn_clr = 1'b1;
        load    = 1'b1;
        d       = 8'h55;
        en      = 1'b1;
        up      = 1'b1;
        step();
        chk("prio_clr", 8'h00, 1'b0, 1'b1);
        // Load beats count: no increment on loaded value.
        syn_clr = 1'b0;
        step();
        chk("prio_load", 8'h55, 1'b0, 1'b0);

        // Load all-ones raises max_tick next cycle.
        en   = 1'b0;
        d    = 8'hFF;
        step();
        chk("load_ff", 8'hFF, 1'b1, 1'b0);

        // Asynchronous reset mid-count.
        d = 8'h30;
        step();
        chk("async_pre", 8'h30, 1'b0, 1'b0);
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        step();
        chk("async_cnt", 8'h31, 1'b0, 1'b0);
        #4;
        reset = 1'b1;
        #1;
        chk("async_rst", 8'h00, 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        step();
        chk("async_resume", 8'h01, 1'b0, 1'b0);

        // Enable gating: up toggles but nothing moves.
        en   = 1'b0;
        load = 1'b1;
        d    = 8'h10;
        step();
        load = 1'b0;
        chk("gate_load", 8'h10, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            up = ~up;
            step();
            chk("gate_hold", 8'h10, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_universal_bin_counter
